// File: rtl/dbus_pkg.sv
// Shared data-bus types and widths.
// Used by the arbiter and the address decoder.
package dbus_pkg;

  localparam int DBUS_AW = 32;
  localparam int DBUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } dbus_arb_state_t;

endpackage

// File: rtl/dbus_wdt.sv
// Grant watchdog: counts grant cycles without slave ready.
// Pulses expire when the count reaches TIMEOUT.
module dbus_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstb,
  input  logic en_i,
  input  logic clr_i,
  input  logic done_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;

  assign expire_o = en_i & (cnt_q == 16'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i | done_i | expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master round-robin data-bus arbiter with a
// watchdog that completes unanswered transactions.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] m0_addr,
  input  logic        m0_rd_req,
  input  logic        m0_wr_req,
  input  logic [3:0]  m0_wr_be,
  input  logic [31:0] m0_wr_data,
  output logic        m0_rd_ready,
  output logic        m0_wr_ready,
  output logic [31:0] m0_rd_data,
  input  logic [31:0] m1_addr,
  input  logic        m1_rd_req,
  input  logic        m1_wr_req,
  input  logic [3:0]  m1_wr_be,
  input  logic [31:0] m1_wr_data,
  output logic        m1_rd_ready,
  output logic        m1_wr_ready,
  output logic [31:0] m1_rd_data,
  output logic [31:0] s_addr,
  output logic        s_rd_req,
  output logic        s_wr_req,
  output logic [3:0]  s_wr_be,
  output logic [31:0] s_wr_data,
  input  logic        s_rd_ready,
  input  logic        s_wr_ready,
  input  logic [31:0] s_rd_data,
  output logic        err_flag,
  output logic        err_id,
  input  logic        err_clr
);

  dbus_arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic err_flag_q, err_id_q;

  logic m0_req, m1_req;
  logic gnt, sel;
  logic rd_req_x, wr_req_x;
  logic rd_rdy, wr_rdy;
  logic [DBUS_DW-1:0] rdata;
  logic wdt_done, expire;

  assign m0_req = m0_rd_req | m0_wr_req;
  assign m1_req = m1_rd_req | m1_wr_req;
  assign gnt    = (state_q != IDLE);
  assign sel    = (state_q == GNT1);

  assign rd_req_x = gnt & (sel ? m1_rd_req : m0_rd_req);
  assign wr_req_x = gnt & (sel ? m1_wr_req : m0_wr_req);

  // Counter reset on slave ready uses the raw request, not the gated one
  assign wdt_done = (s_rd_ready & rd_req_x) |
                    (s_wr_ready & wr_req_x);

  dbus_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .rstb    (rstb),
    .en_i    (gnt),
    .clr_i   (~gnt),
    .done_i  (wdt_done),
    .expire_o(expire)
  );

  always_comb begin
    s_addr    = '0;
    s_wr_be   = '0;
    s_wr_data = '0;
    if (gnt) begin
      s_addr    = sel ? m1_addr    : m0_addr;
      s_wr_be   = sel ? m1_wr_be   : m0_wr_be;
      s_wr_data = sel ? m1_wr_data : m0_wr_data;
    end
  end

  assign s_rd_req = rd_req_x & ~expire;
  assign s_wr_req = wr_req_x & ~expire;

  assign rd_rdy = (s_rd_ready & s_rd_req) | (expire & rd_req_x);
  assign wr_rdy = (s_wr_ready & s_wr_req) | (expire & wr_req_x);
  assign rdata  = expire ? ERR_DATA : s_rd_data;

  always_comb begin
    m0_rd_ready = 1'b0;
    m0_wr_ready = 1'b0;
    m0_rd_data  = '0;
    m1_rd_ready = 1'b0;
    m1_wr_ready = 1'b0;
    m1_rd_data  = '0;
    if (state_q == GNT0) begin
      m0_rd_ready = rd_rdy;
      m0_wr_ready = wr_rdy;
      m0_rd_data  = rdata;
    end
    if (state_q == GNT1) begin
      m1_rd_ready = rd_rdy;
      m1_wr_ready = wr_rdy;
      m1_rd_data  = rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          m0_req & m1_req:
            state_d = last_q ? GNT0 : GNT1;
          m0_req & ~m1_req: state_d = GNT0;
          ~m0_req & m1_req: state_d = GNT1;
          default:          state_d = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        // A dropped request also ends the grant
        if (rd_rdy | wr_rdy | ~(rd_req_x | wr_req_x)) begin
          state_d = IDLE;
          last_d  = sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      err_flag_q <= 1'b0;
      err_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (err_clr) begin
        err_flag_q <= 1'b0;
      end else if (expire) begin
        err_flag_q <= 1'b1;
      end
      if (expire) begin
        err_id_q <= sel;
      end
    end
  end

  assign err_flag = err_flag_q;
  assign err_id   = err_id_q;

endmodule
